mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Parametrised synchronous memory controller between the core's byte-wide bus (address/in/out/we) and a wide block RAM. It replaces the fixed one-cycle byte RAM model with a request/ready handshake, a configurable RAM word width with byte-lane enables, and programmable wait states. It also adds a write-protected ROM window for the BIOS region and a one-word read buffer that serves repeated reads to the same word without a RAM access.

## Interface
- `ADDR_W`, 20, byte-address width used; higher address bits are ignored.
- `DATA_W`, 32, RAM word width; must be a multiple of 8 (8, 16, 32 or 64).
- `WAIT`, 0, extra wait cycles inserted before every RAM access (0..15).
- `ROM_BASE`, 20'hF8000, first byte address of the write-protected window, which extends to the top of the `ADDR_W` space.
- `ROM_EN`, 1, 1 enables write protection; 0 makes the whole space writable.
- `clock`  in  1  single clock; every register is on its rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `address`  in  32  CPU byte address; only bits `[ADDR_W-1:0]` are used.
- `wdata`  in  8  CPU write byte.
- `we`  in  1  1 = write, 0 = read; sampled together with `req`.
- `req`  in  1  access strobe.
- `rdata`  out  8  read byte.
- `ready`  out  1  one-cycle completion pulse.
- `wr_fault`  out  1  one-cycle pulse when a write to the ROM window is dropped.
- `ram_addr`  out  `ADDR_W-log2(DATA_W/8)`  RAM word address.
- `ram_en`  out  1  RAM access enable.
- `ram_we`  out  1  RAM write enable.
- `ram_be`  out  `DATA_W/8`  byte-lane enables.
- `ram_wdata`  out  `DATA_W`  RAM write data.
- `ram_rdata`  in  `DATA_W`  RAM read data, valid one cycle after a cycle with `ram_en`=1 and `ram_we`=0.

## Operation
- Address split:
  - lane = `address[log2(DATA_W/8)-1:0]`; lane is 0 when `DATA_W`=8.
  - word = the remaining bits up to `ADDR_W`.
- FSM states are IDLE, WAIT, ACCESS, CAPTURE and DONE.
- IDLE: `req`=1 latches `address`, `we` and `wdata`. The latched values are used for the whole transaction.
  - Read hit (buffer valid and tag == word): go to DONE. `rdata` is taken from the buffer. No RAM access and no wait states.
  - Write to ROM window (`ROM_EN`=1, address >= `ROM_BASE`): go to DONE with `wr_fault`=1. RAM and buffer are unchanged.
  - Otherwise: go to WAIT if `WAIT`>0, else go to ACCESS.
- WAIT: the counter loads `WAIT-1` on entry and decrements each cycle. The FSM moves to ACCESS when the counter reaches 0.
- ACCESS: `ram_en`=1 and `ram_addr`=word.
  - Write: `ram_we`=1, `ram_be`=one-hot(lane), `wdata` replicated on every lane of `ram_wdata`. If the buffer tag matches, the buffer byte is updated (write-through). Next state is DONE.
  - Read: `ram_we`=0. Next state is CAPTURE.
- CAPTURE: `ram_rdata` is loaded into the buffer, the tag is set to word, valid is set, and `rdata` = lane byte. Next state is DONE.
- DONE: `ready`=1 for exactly one cycle, then IDLE.
- `req` outside IDLE is ignored and not queued. The CPU holds off new requests until `ready`.
- Address bits at or above `ADDR_W` are dropped, so the address space wraps modulo 2^`ADDR_W`.

## Timing
- Values after reset:
  - Outputs: `ready`=0, `wr_fault`=0, `rdata`=8'h00, `ram_en`=0, `ram_we`=0, `ram_be`=0, `ram_addr`=0, `ram_wdata`=0.
  - Internal: FSM in IDLE, buffer invalid.
- `reset_n` low mid-transaction aborts immediately. No RAM write is issued after reset assertion.
- Latency, counted as cycles from the `req`-sampled edge to `ready` high:
  - read hit: 1
  - read miss: `WAIT`+3
  - write: `WAIT`+2
  - ROM-fault write: 1
- `rdata` is registered. It is valid while `ready` is high and holds until the next read completes; writes do not change it.
- Only ACCESS drives `ram_en`, `ram_we` and `ram_be` non-zero.
- A write that hits the buffer tag takes effect in the buffer at the same edge as the RAM write, so an immediately following read returns the new byte.

## Structure
- Package `mem_pkg` holds:
  - the state enum (IDLE, WAIT, ACCESS, CAPTURE, DONE);
  - the localparams LANES = `DATA_W/8`, LANE_W = log2(LANES) and WORD_W = `ADDR_W`-LANE_W;
  - function `is_rom(addr)`.
- One sub-module, `mem_line_buf`: tag, valid, data word, byte-lane update and hit compare. The FSM, wait counter and RAM port drive logic stay in `mem_ctrl`.

## Test plan
- Reset with `DATA_W`=32, `WAIT`=0 -> all outputs 0; first read of 0x00100 (RAM word 0x11223344) gives `ram_en` 1 cycle after `req`, and `ready` plus `rdata`=8'h44 3 cycles after `req`.
- Read 0x00101 immediately after -> buffer hit: `ready` 1 cycle after `req`, `rdata`=8'h33, `ram_en` stays 0.
- Write 8'hAA to 0x00102 with `WAIT`=2 -> `ram_be`=4'b0100, `ram_wdata`=32'hAAAAAAAA, `ready` 4 cycles after `req`; a following read of 0x00102 hits the buffer and gives 8'hAA.
- Write 8'h55 to 0xF8010 with `ROM_EN`=1 -> `ready` and `wr_fault` both high 1 cycle after `req`; `ram_en`=0 throughout; a read of 0xF8010 returns the original ROM byte.
- `address`=0x001FFFFF with `ADDR_W`=20 -> `ram_addr` = word of 0xFFFFF (wrap); `req` pulsed again during WAIT is ignored, giving exactly one `ready`.
- `reset_n` pulsed low during WAIT of a write -> no `ram_we` pulse afterwards; FSM in IDLE; next read of the same word misses (buffer invalid).

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the memory controller slice.
package mem_pkg;

  // Default geometry: 20-bit byte space over a 32-bit RAM word
  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 32;
  localparam int LANES      = DATA_W_DEF / 8;
  localparam int LANE_W     = $clog2(LANES);
  localparam int WORD_W     = ADDR_W_DEF - LANE_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  // Number of byte lanes in a RAM word of the given width
  function automatic int lanes_of(input int data_w);
    return data_w / 8;
  endfunction

  // Number of address bits that select a lane (0 for a byte-wide RAM)
  function automatic int lane_w_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // True when the (already wrapped) byte address lies in the protected window
  function automatic logic is_rom(input logic [31:0] addr,
                                  input logic [31:0] rom_base,
                                  input logic        rom_en);
    return rom_en && (addr >= rom_base);
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU byte bus plus wide RAM port of the memory controller.
interface mem_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  import mem_pkg::*;

  localparam int NL = lanes_of(DATA_W);
  localparam int WW = ADDR_W - lane_w_of(DATA_W);

  logic [31:0]       address;
  logic [7:0]        wdata;
  logic              we;
  logic              req;
  logic [7:0]        rdata;
  logic              ready;
  logic              wr_fault;
  logic [WW-1:0]     ram_addr;
  logic              ram_en;
  logic              ram_we;
  logic [NL-1:0]     ram_be;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // CPU and RAM model side
  modport master (
    output address, wdata, we, req, ram_rdata,
    input  rdata, ready, wr_fault, ram_addr, ram_en, ram_we, ram_be, ram_wdata
  );

  // Controller side
  modport slave (
    input  address, wdata, we, req, ram_rdata,
    output rdata, ready, wr_fault, ram_addr, ram_en, ram_we, ram_be, ram_wdata
  );

endinterface

// File: rtl/mem_ctrl_line_buf.sv
// One-word read buffer: tag, valid, data word, byte write-through and hit compare.
module mem_line_buf #(
  parameter int DATA_W = 32,
  parameter int WORD_W = 18,
  parameter int LW     = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] i_look_word,
  input  logic [LW-1:0]     i_look_lane,
  output logic              o_hit,
  output logic [7:0]        o_byte,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_load_word,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_wr,
  input  logic [WORD_W-1:0] i_wr_word,
  input  logic [LW-1:0]     i_wr_lane,
  input  logic [7:0]        i_wr_byte
);

  logic              r_valid;
  logic [WORD_W-1:0] r_tag;
  logic [DATA_W-1:0] r_data;

  // Fill on a RAM read capture; otherwise patch one byte when a write hits the tag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_tag   <= i_load_word;
      r_data  <= i_load_data;
    end else if (i_wr && r_valid && (r_tag == i_wr_word)) begin
      r_data[i_wr_lane*8 +: 8] <= i_wr_byte;
    end
  end

  // Hit compare and lane select for the incoming request address
  always_comb begin
    o_hit  = r_valid && (r_tag == i_look_word);
    o_byte = r_data[i_look_lane*8 +: 8];
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-bus to wide-RAM controller with wait states, ROM write protection and a read buffer.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int          ADDR_W   = 20,
  parameter int          DATA_W   = 32,
  parameter int          WAIT     = 0,
  parameter logic [31:0] ROM_BASE = 32'h000F_8000,
  parameter bit          ROM_EN   = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  mem_ctrl_if.slave  bus
);

  localparam int NL     = lanes_of(DATA_W);
  localparam int LW_RAW = lane_w_of(DATA_W);
  localparam int LW     = (LW_RAW > 0) ? LW_RAW : 1;
  localparam int WW     = ADDR_W - LW_RAW;
  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t r_state;
  state_t w_next;

  logic [3:0]    r_cnt;
  logic [WW-1:0] r_word;
  logic [LW-1:0] r_lane;
  logic          r_we;
  logic [7:0]    r_wdata;
  logic [7:0]    r_rdata;
  logic          r_fault;

  logic [ADDR_W-1:0] w_addr;
  logic [WW-1:0]     w_word;
  logic [LW-1:0]     w_lane;
  logic              w_rom;
  logic              w_hit;
  logic [7:0]        w_bufByte;
  logic [NL-1:0]     w_be;
  logic              w_unused;

  // Upper address bits are deliberately dropped so the space wraps
  assign w_unused = ^bus.address;
  assign w_addr   = bus.address[ADDR_W-1:0];
  assign w_rom    = is_rom(32'(w_addr), ROM_BASE, ROM_EN);

  generate
    if (LW_RAW > 0) begin : g_lanes
      assign w_word = w_addr[ADDR_W-1:LW_RAW];
      assign w_lane = w_addr[LW_RAW-1:0];
    end else begin : g_noLanes
      assign w_word = w_addr;
      assign w_lane = '0;
    end
  endgenerate

  mem_line_buf #(
    .DATA_W (DATA_W),
    .WORD_W (WW),
    .LW     (LW)
  ) u_buf (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_look_word (w_word),
    .i_look_lane (w_lane),
    .o_hit       (w_hit),
    .o_byte      (w_bufByte),
    .i_load      (r_state == ST_CAPTURE),
    .i_load_word (r_word),
    .i_load_data (bus.ram_rdata),
    .i_wr        ((r_state == ST_ACCESS) && r_we),
    .i_wr_word   (r_word),
    .i_wr_lane   (r_lane),
    .i_wr_byte   (r_wdata)
  );

  // State register; reset aborts any transaction in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode: hits and ROM-write faults finish without touching RAM
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.req) begin
          if (!bus.we && w_hit)     w_next = ST_DONE;
          else if (bus.we && w_rom) w_next = ST_DONE;
          else if (WAIT > 0)        w_next = ST_WAIT;
          else                      w_next = ST_ACCESS;
        end
      end
      ST_WAIT:    if (r_cnt == 4'd0) w_next = ST_ACCESS;
      ST_ACCESS:  w_next = r_we ? ST_DONE : ST_CAPTURE;
      ST_CAPTURE: w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Transaction latches, wait counter and registered read byte
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= 4'd0;
      r_word  <= '0;
      r_lane  <= '0;
      r_we    <= 1'b0;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
      r_fault <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && bus.req) begin
        r_word  <= w_word;
        r_lane  <= w_lane;
        r_we    <= bus.we;
        r_wdata <= bus.wdata;
        r_fault <= bus.we && w_rom;
        if (!bus.we && w_hit) r_rdata <= w_bufByte;
      end
      if (r_state == ST_CAPTURE) r_rdata <= bus.ram_rdata[r_lane*8 +: 8];
      if ((w_next == ST_WAIT) && (r_state != ST_WAIT)) r_cnt <= WAIT_LOAD;
      else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) r_cnt <= r_cnt - 4'd1;
    end
  end

  // RAM port is only active in ACCESS; CPU status comes from DONE
  always_comb begin
    w_be = '0;
    for (int i = 0; i < NL; i++) w_be[i] = (r_lane == LW'(i));
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_be    = '0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (r_state == ST_ACCESS) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = r_word;
      if (r_we) begin
        bus.ram_we    = 1'b1;
        bus.ram_be    = w_be;
        bus.ram_wdata = {NL{r_wdata}};
      end
    end
    bus.ready    = (r_state == ST_DONE);
    bus.wr_fault = (r_state == ST_DONE) && r_fault;
    bus.rdata    = r_rdata;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: one instance with no wait states, one with two.
module tb_mem_ctrl;

  logic        clock;
  logic        reset_n;
  logic        sel;
  logic [31:0] address;
  logic [7:0]  wdata;
  logic        we;
  logic        req;
  logic [31:0] ramRd0, ramRd2;

  int passed = 0;
  int total  = 0;

  mem_ctrl_if #(.ADDR_W(20), .DATA_W(32)) bus0 ();
  mem_ctrl_if #(.ADDR_W(20), .DATA_W(32)) bus2 ();

  mem_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT(0), .ROM_BASE(32'h000F8000), .ROM_EN(1'b1))
    dut0 (.clock(clock), .reset_n(reset_n), .bus(bus0));
  mem_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT(2), .ROM_BASE(32'h000F8000), .ROM_EN(1'b1))
    dut2 (.clock(clock), .reset_n(reset_n), .bus(bus2));

  assign bus0.address = address;
  assign bus0.wdata   = wdata;
  assign bus0.we      = we;
  assign bus0.req     = req && !sel;
  assign bus0.ram_rdata = ramRd0;
  assign bus2.address = address;
  assign bus2.wdata   = wdata;
  assign bus2.we      = we;
  assign bus2.req     = req && sel;
  assign bus2.ram_rdata = ramRd2;

  logic        mReady, mFault, mRamEn, mRamWe;
  logic [7:0]  mRdata;
  logic [3:0]  mRamBe;
  logic [17:0] mRamAddr;
  logic [31:0] mRamWdata;
  assign mReady    = sel ? bus2.ready     : bus0.ready;
  assign mFault    = sel ? bus2.wr_fault  : bus0.wr_fault;
  assign mRamEn    = sel ? bus2.ram_en    : bus0.ram_en;
  assign mRamWe    = sel ? bus2.ram_we    : bus0.ram_we;
  assign mRdata    = sel ? bus2.rdata     : bus0.rdata;
  assign mRamBe    = sel ? bus2.ram_be    : bus0.ram_be;
  assign mRamAddr  = sel ? bus2.ram_addr  : bus0.ram_addr;
  assign mRamWdata = sel ? bus2.ram_wdata : bus0.ram_wdata;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sparse RAM model; keys above 0x100000 belong to the WAIT=2 instance
  logic [31:0] mem [int];

  function automatic logic [31:0] memRead(input int key);
    if (mem.exists(key)) return mem[key];
    return 32'hC0DE0000 | 32'(key & 32'h0000FFFF);
  endfunction

  function automatic void memWrite(input int key, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] t = memRead(key);
    for (int i = 0; i < 4; i++) if (be[i]) t[i*8 +: 8] = d[i*8 +: 8];
    mem[key] = t;
  endfunction

  always @(posedge clock) begin
    if (bus0.ram_en && bus0.ram_we)  memWrite(int'(bus0.ram_addr), bus0.ram_be, bus0.ram_wdata);
    if (bus0.ram_en && !bus0.ram_we) ramRd0 <= memRead(int'(bus0.ram_addr));
    if (bus2.ram_en && bus2.ram_we)  memWrite(int'(bus2.ram_addr) + 32'h100000, bus2.ram_be, bus2.ram_wdata);
    if (bus2.ram_en && !bus2.ram_we) ramRd2 <= memRead(int'(bus2.ram_addr) + 32'h100000);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  // Issue one request and follow it to ready (entered and left at posedge+1)
  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic w, input logic [7:0] d,
                               output int lat, output int enCnt, output logic [7:0] rd, output logic flt,
                               output logic [3:0] be, output logic [31:0] wd, output logic [17:0] ra);
    sel = s; address = a; we = w; wdata = d; req = 1'b1;
    lat = -1; enCnt = 0; rd = 8'hxx; flt = 1'bx; be = 4'h0; wd = 32'h0; ra = 18'h0;
    @(posedge clock); #1; req = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (mRamEn) begin enCnt++; be = mRamBe; wd = mRamWdata; ra = mRamAddr; end
      if (mReady) begin lat = k; rd = mRdata; flt = mFault; break; end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
  endtask

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic        w;
    logic [7:0]  d;
    logic [7:0]  expRd;
    logic        expFlt;
    int          expLat;
    int          expEn;
    logic [3:0]  expBe;
    logic [31:0] expWd;
    logic [17:0] expAddr;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lat, enCnt, rdyCnt, weCnt, firstLat;
    logic [7:0] rd;
    logic flt;
    logic [3:0] be;
    logic [31:0] wd;
    logic [17:0] ra;

    vecs[0]  = '{1'b0, 32'h00000100, 1'b0, 8'h00, 8'h44, 1'b0, 3, 1, 4'h0, 32'h0, 18'h00040};
    vecs[1]  = '{1'b0, 32'h00000101, 1'b0, 8'h00, 8'h33, 1'b0, 1, 0, 4'h0, 32'h0, 18'h0};
    vecs[2]  = '{1'b0, 32'h00000103, 1'b0, 8'h00, 8'h11, 1'b0, 1, 0, 4'h0, 32'h0, 18'h0};
    vecs[3]  = '{1'b1, 32'h00000100, 1'b0, 8'h00, 8'h44, 1'b0, 5, 1, 4'h0, 32'h0, 18'h00040};
    vecs[4]  = '{1'b1, 32'h00000102, 1'b1, 8'hAA, 8'h44, 1'b0, 4, 1, 4'b0100, 32'hAAAAAAAA, 18'h00040};
    vecs[5]  = '{1'b1, 32'h00000102, 1'b0, 8'h00, 8'hAA, 1'b0, 1, 0, 4'h0, 32'h0, 18'h0};
    vecs[6]  = '{1'b0, 32'h000F8010, 1'b1, 8'h55, 8'h11, 1'b1, 1, 0, 4'h0, 32'h0, 18'h0};
    vecs[7]  = '{1'b0, 32'h000F8010, 1'b0, 8'h00, 8'h0D, 1'b0, 3, 1, 4'h0, 32'h0, 18'h3E004};
    vecs[8]  = '{1'b0, 32'h00300100, 1'b0, 8'h00, 8'h44, 1'b0, 3, 1, 4'h0, 32'h0, 18'h00040};
    vecs[9]  = '{1'b0, 32'h00000101, 1'b1, 8'h12, 8'h44, 1'b0, 2, 1, 4'b0010, 32'h12121212, 18'h00040};
    vecs[10] = '{1'b0, 32'h00100101, 1'b0, 8'h00, 8'h12, 1'b0, 1, 0, 4'h0, 32'h0, 18'h0};

    mem[32'h00040]  = 32'h11223344;
    mem[32'h3E004]  = 32'h0BADF00D;
    mem[32'h100040] = 32'h11223344;
    mem[32'h13E004] = 32'h0BADF00D;

    reset_n = 1'b0; sel = 1'b0; address = '0; wdata = '0; we = 1'b0; req = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checkOutput($sformatf("reset%0d ready", s),     32'(mReady),    32'h0);
      checkOutput($sformatf("reset%0d wr_fault", s),  32'(mFault),    32'h0);
      checkOutput($sformatf("reset%0d rdata", s),     32'(mRdata),    32'h0);
      checkOutput($sformatf("reset%0d ram_en", s),    32'(mRamEn),    32'h0);
      checkOutput($sformatf("reset%0d ram_we", s),    32'(mRamWe),    32'h0);
      checkOutput($sformatf("reset%0d ram_be", s),    32'(mRamBe),    32'h0);
      checkOutput($sformatf("reset%0d ram_addr", s),  32'(mRamAddr),  32'h0);
      checkOutput($sformatf("reset%0d ram_wdata", s), mRamWdata,      32'h0);
    end
    @(posedge clock); #1;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].s, vecs[i].a, vecs[i].w, vecs[i].d, lat, enCnt, rd, flt, be, wd, ra);
      checkOutput($sformatf("v%0d latency", i),  32'(lat),   32'(vecs[i].expLat));
      checkOutput($sformatf("v%0d ram_en", i),   32'(enCnt), 32'(vecs[i].expEn));
      checkOutput($sformatf("v%0d rdata", i),    32'(rd),    32'(vecs[i].expRd));
      checkOutput($sformatf("v%0d wr_fault", i), 32'(flt),   32'(vecs[i].expFlt));
      if (vecs[i].expEn > 0)
        checkOutput($sformatf("v%0d ram_addr", i), 32'(ra), 32'(vecs[i].expAddr));
      if (vecs[i].w && vecs[i].expEn > 0) begin
        checkOutput($sformatf("v%0d ram_be", i),    32'(be), 32'(vecs[i].expBe));
        checkOutput($sformatf("v%0d ram_wdata", i), wd,      vecs[i].expWd);
      end
    end

    // Wrapped read on the WAIT=2 instance with a second req during WAIT
    sel = 1'b1; address = 32'h001FFFFF; we = 1'b0; req = 1'b1;
    @(posedge clock); #1;
    address = 32'h00000200; req = 1'b1;
    rdyCnt = 0; enCnt = 0; firstLat = -1; ra = '0; rd = 8'h00;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (mRamEn) begin enCnt++; ra = mRamAddr; end
      if (mReady) begin
        rdyCnt++;
        if (firstLat < 0) begin firstLat = k; rd = mRdata; end
      end
      @(posedge clock); #1;
      req = 1'b0;
    end
    checkOutput("wrap ready count", 32'(rdyCnt),   32'd1);
    checkOutput("wrap latency",     32'(firstLat), 32'd5);
    checkOutput("wrap ram_en",      32'(enCnt),    32'd1);
    checkOutput("wrap ram_addr",    32'(ra),       32'h3FFFF);
    checkOutput("wrap rdata",       32'(rd),       32'hC0);

    // Load the buffer, then reset in the middle of a write's WAIT
    applyStimulus(1'b1, 32'h00000100, 1'b0, 8'h00, lat, enCnt, rd, flt, be, wd, ra);
    checkOutput("pre-reset latency", 32'(lat), 32'd5);
    checkOutput("pre-reset rdata",   32'(rd),  32'h44);
    sel = 1'b1; address = 32'h00000103; we = 1'b1; wdata = 8'h77; req = 1'b1;
    @(posedge clock); #1;
    req = 1'b0; reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    weCnt = 0; rdyCnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (mRamWe || mRamEn) weCnt++;
      if (mReady) rdyCnt++;
    end
    @(posedge clock); #1;
    checkOutput("abort ram access", 32'(weCnt),  32'd0);
    checkOutput("abort ready",      32'(rdyCnt), 32'd0);
    checkOutput("abort rdata",      32'(mRdata), 32'h00);
    applyStimulus(1'b1, 32'h00000103, 1'b0, 8'h00, lat, enCnt, rd, flt, be, wd, ra);
    checkOutput("post-reset latency", 32'(lat),   32'd5);
    checkOutput("post-reset ram_en",  32'(enCnt), 32'd1);
    checkOutput("post-reset rdata",   32'(rd),    32'h11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
